// File: rtl/xlconstant_bank_if.sv
// Write/commit bus and constant outputs of the constant bank.
// The master side stages channel values and requests commits; the slave side
// (the bank) reports readiness, the live channel values and error/pulse flags.
interface xlconstant_bank_if #(
  parameter int CONST_WIDTH = 8,
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 4
);
  logic                          wr_valid;
  logic                          wr_ready;
  logic [ADDR_W-1:0]             wr_addr;
  logic [CONST_WIDTH-1:0]        wr_data;
  logic                          wr_mode;
  logic                          commit;
  logic [NUM_CH*CONST_WIDTH-1:0] dout;
  logic [NUM_CH-1:0]             pulse_active;
  logic                          wr_err;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_mode, commit,
    input  wr_ready, dout, pulse_active, wr_err
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_mode, commit,
    output wr_ready, dout, pulse_active, wr_err
  );
endinterface

// File: rtl/xlconstant_bank.sv
// Bank of NUM_CH constant channels. Writes are staged per channel and applied
// atomically by a one-cycle APPLY state. A channel applied in pulse mode
// shows its value for PULSE_CYCLES cycles and then falls back to CONST_VAL;
// a level-mode channel holds its value until it is committed again.
module xlconstant_bank #(
  parameter int          CONST_WIDTH  = 8,
  parameter int          NUM_CH       = 4,
  parameter logic [31:0] CONST_VAL    = 32'h0000_0000,
  parameter int          ADDR_W       = 4,
  parameter int          PULSE_CYCLES = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  xlconstant_bank_if.slave bus
);

  localparam int CNT_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [CONST_WIDTH-1:0] LP_CONST  = CONST_VAL[CONST_WIDTH-1:0];
  localparam logic [CNT_W-1:0]       LP_PULSE  = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0]       LP_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]       LP_ZERO   = CNT_W'(0);
  localparam logic [ADDR_W:0]        LP_NUM_CH = (ADDR_W + 1)'(NUM_CH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_t;

  // An address is valid when it names an existing channel; the extra MSB keeps
  // the compare exact when NUM_CH equals 2**ADDR_W.
  function automatic logic f_in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < LP_NUM_CH);
  endfunction

  // Registered state
  state_t                          r_state;
  logic                            r_wr_ready;
  logic                            r_wr_err;
  logic [CONST_WIDTH-1:0]          r_stage [NUM_CH];
  logic [NUM_CH-1:0]               r_mode;
  logic [NUM_CH-1:0]               r_dirty;
  logic [CNT_W-1:0]                r_cnt   [NUM_CH];
  logic [NUM_CH*CONST_WIDTH-1:0]   r_dout;
  logic [NUM_CH-1:0]               r_pact;

  // Next-state values
  state_t                          w_state_nxt;
  logic                            w_wr_ready_nxt;
  logic                            w_apply;
  logic                            w_wr_fire;
  logic                            w_in_range;
  logic                            w_wr_err_nxt;
  logic [CONST_WIDTH-1:0]          w_stage_nxt [NUM_CH];
  logic [NUM_CH-1:0]               w_mode_nxt;
  logic [NUM_CH-1:0]               w_dirty_nxt;
  logic [CNT_W-1:0]                w_cnt_nxt   [NUM_CH];
  logic [NUM_CH*CONST_WIDTH-1:0]   w_dout_nxt;
  logic [NUM_CH-1:0]               w_pact_nxt;

  // Handshake qualifiers: writes are taken only while the bank is idle
  assign w_wr_fire    = bus.wr_valid & r_wr_ready;
  assign w_in_range   = f_in_range(bus.wr_addr);
  assign w_wr_err_nxt = w_wr_fire & ~w_in_range;

  // Commit sequencer state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= ST_IDLE;
      r_wr_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ready <= w_wr_ready_nxt;
    end
  end

  // Commit sequencer next state; APPLY always lasts one cycle and ignores commit
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_ready_nxt = 1'b1;
    w_apply        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.commit) begin
          w_state_nxt    = ST_APPLY;
          w_wr_ready_nxt = 1'b0;
        end else begin
          w_state_nxt    = ST_IDLE;
          w_wr_ready_nxt = 1'b1;
        end
      end
      ST_APPLY: begin
        w_state_nxt    = ST_IDLE;
        w_wr_ready_nxt = 1'b1;
        w_apply        = 1'b1;
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_wr_ready_nxt = 1'b1;
        w_apply        = 1'b0;
      end
    endcase
  end

  // Per-channel staging, apply and pulse countdown; an apply overrides the
  // countdown so a reloaded pulse never shows CONST_VAL in between
  always_comb begin
    w_stage_nxt = r_stage;
    w_mode_nxt  = r_mode;
    w_dirty_nxt = r_dirty;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = r_dout;
    w_pact_nxt  = r_pact;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (w_apply && r_dirty[ch]) begin
        w_dout_nxt[ch*CONST_WIDTH +: CONST_WIDTH] = r_stage[ch];
        w_cnt_nxt[ch] = r_mode[ch] ? LP_PULSE : LP_ZERO;
      end else if (r_cnt[ch] == LP_ONE) begin
        w_dout_nxt[ch*CONST_WIDTH +: CONST_WIDTH] = LP_CONST;
        w_cnt_nxt[ch] = LP_ZERO;
      end else if (r_cnt[ch] != LP_ZERO) begin
        w_dout_nxt[ch*CONST_WIDTH +: CONST_WIDTH] = r_dout[ch*CONST_WIDTH +: CONST_WIDTH];
        w_cnt_nxt[ch] = r_cnt[ch] - LP_ONE;
      end else begin
        w_dout_nxt[ch*CONST_WIDTH +: CONST_WIDTH] = r_dout[ch*CONST_WIDTH +: CONST_WIDTH];
        w_cnt_nxt[ch] = r_cnt[ch];
      end

      if (w_apply) begin
        w_stage_nxt[ch] = r_stage[ch];
        w_mode_nxt[ch]  = r_mode[ch];
        w_dirty_nxt[ch] = 1'b0;
      end else if (w_wr_fire && w_in_range && (bus.wr_addr == ADDR_W'(ch))) begin
        w_stage_nxt[ch] = bus.wr_data;
        w_mode_nxt[ch]  = bus.wr_mode;
        w_dirty_nxt[ch] = 1'b1;
      end else begin
        w_stage_nxt[ch] = r_stage[ch];
        w_mode_nxt[ch]  = r_mode[ch];
        w_dirty_nxt[ch] = r_dirty[ch];
      end

      w_pact_nxt[ch] = (w_cnt_nxt[ch] != LP_ZERO);
    end
  end

  // Channel datapath registers; reset restores every channel to CONST_VAL
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_stage[ch] <= LP_CONST;
        r_cnt[ch]   <= LP_ZERO;
      end
      r_mode   <= {NUM_CH{1'b0}};
      r_dirty  <= {NUM_CH{1'b0}};
      r_dout   <= {NUM_CH{LP_CONST}};
      r_pact   <= {NUM_CH{1'b0}};
      r_wr_err <= 1'b0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_stage[ch] <= w_stage_nxt[ch];
        r_cnt[ch]   <= w_cnt_nxt[ch];
      end
      r_mode   <= w_mode_nxt;
      r_dirty  <= w_dirty_nxt;
      r_dout   <= w_dout_nxt;
      r_pact   <= w_pact_nxt;
      r_wr_err <= w_wr_err_nxt;
    end
  end

  assign bus.wr_ready     = r_wr_ready;
  assign bus.dout         = r_dout;
  assign bus.pulse_active = r_pact;
  assign bus.wr_err       = r_wr_err;

endmodule

// File: tb/tb_xlconstant_bank.sv
// Self-checking bench for xlconstant_bank: directed scenarios with literal
// expectations followed by random traffic, all checked every cycle against a
// timestamp-based model of the channels.
module tb_xlconstant_bank;
  localparam int          CW  = 8;
  localparam int          NCH = 4;
  localparam int          AW  = 4;
  localparam int          PC  = 3;
  localparam logic [7:0]  CV  = 8'h5A;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;

  always #5 aclk = ~aclk;

  xlconstant_bank_if #(.CONST_WIDTH(CW), .NUM_CH(NCH), .ADDR_W(AW)) bus ();

  xlconstant_bank #(
    .CONST_WIDTH (CW),
    .NUM_CH      (NCH),
    .CONST_VAL   (32'h0000_005A),
    .ADDR_W      (AW),
    .PULSE_CYCLES(PC)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  // Model: each channel has a visible value and the edge number at which a
  // pulse expires (0 = no pulse running).
  int         m_cyc = 0;
  logic [7:0] m_stage [NCH];
  logic       m_mode  [NCH];
  logic       m_dirty [NCH];
  logic [7:0] m_out   [NCH];
  int         m_exp   [NCH];
  logic       m_apply;
  logic       m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_dout();
    logic [31:0] v;
    for (int ch = 0; ch < NCH; ch++) v[ch*8 +: 8] = m_out[ch];
    return v;
  endfunction

  function automatic logic [3:0] model_pact();
    logic [3:0] v;
    for (int ch = 0; ch < NCH; ch++) v[ch] = (m_exp[ch] != 0);
    return v;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      m_stage[ch] = CV;
      m_mode[ch]  = 1'b0;
      m_dirty[ch] = 1'b0;
      m_out[ch]   = CV;
      m_exp[ch]   = 0;
    end
    m_apply = 1'b0;
    m_err   = 1'b0;
  endtask

  // One clock edge of the model, given the inputs the DUT sampled on it.
  task automatic model_step(input logic v, input logic [3:0] a, input logic [7:0] d,
                            input logic m, input logic c);
    bit ready;
    ready = !m_apply;
    m_cyc++;
    for (int ch = 0; ch < NCH; ch++) begin
      if (m_exp[ch] != 0 && m_cyc >= m_exp[ch]) begin
        m_out[ch] = CV;
        m_exp[ch] = 0;
      end
    end
    if (m_apply) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (m_dirty[ch]) begin
          m_out[ch] = m_stage[ch];
          m_exp[ch] = m_mode[ch] ? (m_cyc + PC) : 0;
        end
        m_dirty[ch] = 1'b0;
      end
    end
    m_err = ready && v && (int'(a) >= NCH);
    if (ready && v && int'(a) < NCH) begin
      m_stage[a] = d;
      m_mode[a]  = m;
      m_dirty[a] = 1'b1;
    end
    m_apply = ready && c;
  endtask

  // Every-cycle comparison of all DUT outputs against the model
  always @(negedge aclk) begin
    if (check_en) begin
      check("cycle", {bus.dout, bus.pulse_active, bus.wr_ready, bus.wr_err},
            {model_dout(), model_pact(), !m_apply, m_err});
    end
  end

  task automatic do_cycle(input logic v, input logic [3:0] a, input logic [7:0] d,
                          input logic m, input logic c);
    @(negedge aclk);
    bus.wr_valid = v;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    bus.wr_mode  = m;
    bus.commit   = c;
    @(posedge aclk);
    #1;
    model_step(v, a, d, m, c);
  endtask

  task automatic idle();
    do_cycle(1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic zero_inputs();
    bus.wr_valid = 1'b0;
    bus.wr_addr  = 4'd0;
    bus.wr_data  = 8'h00;
    bus.wr_mode  = 1'b0;
    bus.commit   = 1'b0;
  endtask

  // Asynchronous reset in the middle of a cycle, then synchronous release
  task automatic pulse_reset(input string name);
    check_en = 1'b0;
    #1;
    aresetn = 1'b0;
    zero_inputs();
    #1;
    check({name, "_dout"}, bus.dout, 32'h5A5A5A5A);
    check({name, "_pact"}, bus.pulse_active, 4'b0000);
    check({name, "_ready"}, bus.wr_ready, 1'b1);
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    model_step(1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    check({name, "_ready_after"}, bus.wr_ready, 1'b1);
    check_en = 1'b1;
  endtask

  logic [7:0] exp43 [7];
  int n;

  initial begin
    zero_inputs();
    model_reset();
    #12;
    check("rst_dout", bus.dout, 32'h5A5A5A5A);
    check("rst_ready", bus.wr_ready, 1'b1);
    check("rst_pact", bus.pulse_active, 4'b0000);
    check("rst_err", bus.wr_err, 1'b0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    model_step(1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    check("ready_first_edge", bus.wr_ready, 1'b1);
    check_en = 1'b1;

    // Level write to ch2, commit one cycle later
    do_cycle(1'b1, 4'd2, 8'h11, 1'b0, 1'b0);
    check("stage_no_dout_change", bus.dout, 32'h5A5A5A5A);
    do_cycle(1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
    check("apply_not_ready", bus.wr_ready, 1'b0);
    check("apply_dout_hold", bus.dout, 32'h5A5A5A5A);
    idle();
    check("level_commit", bus.dout, 32'h5A115A5A);
    check("model_level", model_dout(), 32'h5A115A5A);
    check("ready_back", bus.wr_ready, 1'b1);
    repeat (4) idle();
    check("level_hold", bus.dout, 32'h5A115A5A);

    // Pulse write to ch0 on the same edge as commit
    do_cycle(1'b1, 4'd0, 8'hFF, 1'b1, 1'b1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (bus.dout[7:0] == 8'hFF && bus.pulse_active[0]) n++;
    end
    check("pulse_len", n, 3);
    check("pulse_revert", bus.dout, 32'h5A115A5A);
    check("pulse_inactive", bus.pulse_active, 4'b0000);

    // Pulse reload while one cycle remains
    exp43 = '{8'hFF, 8'hFF, 8'hFF, 8'h22, 8'h22, 8'h22, 8'h5A};
    do_cycle(1'b1, 4'd0, 8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      if (i == 2) do_cycle(1'b1, 4'd0, 8'h22, 1'b1, 1'b1);
      else        idle();
      check($sformatf("reload_%0d", i), bus.dout[7:0], exp43[i]);
    end

    // Out-of-range write
    do_cycle(1'b1, 4'd7, 8'h33, 1'b0, 1'b0);
    check("err_set", bus.wr_err, 1'b1);
    do_cycle(1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
    check("err_one_cycle", bus.wr_err, 1'b0);
    idle();
    check("err_no_change", bus.dout, 32'h5A115A5A);

    // Level commit over an active pulse clears it and holds
    do_cycle(1'b1, 4'd1, 8'hC3, 1'b1, 1'b1);
    idle();
    check("pulse_ch1", bus.pulse_active, 4'b0010);
    do_cycle(1'b1, 4'd1, 8'h44, 1'b0, 1'b1);
    idle();
    check("level_over_pulse_pact", bus.pulse_active, 4'b0000);
    repeat (4) idle();
    check("level_over_pulse", bus.dout, 32'h5A11445A);
    check("model_level_over", model_dout(), 32'h5A11445A);

    // Reset during APPLY discards the staged value
    do_cycle(1'b1, 4'd1, 8'h77, 1'b0, 1'b1);
    pulse_reset("rst_apply");
    do_cycle(1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
    idle();
    check("rst_apply_recommit", bus.dout, 32'h5A5A5A5A);

    // Reset during an active pulse
    do_cycle(1'b1, 4'd3, 8'hAB, 1'b1, 1'b1);
    idle();
    check("pulse_ch3", bus.dout, 32'hAB5A5A5A);
    pulse_reset("rst_pulse");
    do_cycle(1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
    idle();
    check("rst_pulse_recommit", bus.dout, 32'h5A5A5A5A);
    check("rst_pulse_pact", bus.pulse_active, 4'b0000);

    // Random traffic checked by the per-cycle compare
    for (int i = 0; i < 800; i++) begin
      do_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), 8'($urandom),
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    @(negedge aclk);
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
